// File: rtl/csr_unit_if.sv
// ============================================================================
// Module      : csr_unit_if
// Description : Execute-stage CSR access bundle between the pipeline and csr_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface csr_unit_if;
    logic        csr_en_i;
    logic [2:0]  csr_op_i;
    logic [11:0] csr_addr_i;
    logic [4:0]  rs1_idx_i;
    logic [31:0] rs1_data_i;
    logic [31:0] imm_ext_i;
    logic        stall_i;
    logic        retire_i;
    logic [31:0] csr_rdata_o;
    logic        illegal_o;

    modport master (
        output csr_en_i, csr_op_i, csr_addr_i, rs1_idx_i, rs1_data_i,
               imm_ext_i, stall_i, retire_i,
        input  csr_rdata_o, illegal_o
    );

    modport slave (
        input  csr_en_i, csr_op_i, csr_addr_i, rs1_idx_i, rs1_data_i,
               imm_ext_i, stall_i, retire_i,
        output csr_rdata_o, illegal_o
    );
endinterface

`default_nettype wire

// File: rtl/csr_unit.sv
// ============================================================================
// Module      : csr_unit
// Description : Zicsr unit with mscratch, mcountinhibit and 64-bit cycle/instret counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_unit (
    input  wire logic   clk_i,
    input  wire logic   reset_i,
    csr_unit_if.slave   bus
);

    localparam logic [11:0] C_ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] C_ADDR_MCOUNTINH = 12'h320;
    localparam logic [11:0] C_ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] C_ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] C_ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] C_ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] C_ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] C_ADDR_CYCLEH    = 12'hC80;
    localparam logic [11:0] C_ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] C_ADDR_INSTRETH  = 12'hC82;

    logic [31:0] mscratch_q, mscratch_d;
    logic        cy_inh_q,   cy_inh_d;
    logic        ir_inh_q,   ir_inh_d;
    logic [63:0] mcycle_q,   mcycle_d;
    logic [63:0] minstret_q, minstret_d;

    logic [31:0] w_operand;
    logic [31:0] w_old;
    logic [31:0] w_new;
    logic        w_hit;
    logic        w_read_only;
    logic        w_op_reserved;
    logic        w_suppress;
    logic        w_illegal;
    logic        w_we;

    always_comb begin
        w_operand     = bus.csr_op_i[2] ? bus.imm_ext_i : bus.rs1_data_i;
        w_op_reserved = (bus.csr_op_i[1:0] == 2'b00);
        // Set/clear with a zero source is a pure read; the source field is rs1 or uimm.
        w_suppress    = bus.csr_op_i[1] &
                        (bus.csr_op_i[2] ? (bus.imm_ext_i[4:0] == 5'd0)
                                         : (bus.rs1_idx_i == 5'd0));

        w_hit       = 1'b1;
        w_read_only = 1'b0;
        w_old       = 32'd0;
        case (bus.csr_addr_i)
            C_ADDR_MSCRATCH:  w_old = mscratch_q;
            C_ADDR_MCOUNTINH: w_old = {29'd0, ir_inh_q, 1'b0, cy_inh_q};
            C_ADDR_MCYCLE:    w_old = mcycle_q[31:0];
            C_ADDR_MCYCLEH:   w_old = mcycle_q[63:32];
            C_ADDR_MINSTRET:  w_old = minstret_q[31:0];
            C_ADDR_MINSTRETH: w_old = minstret_q[63:32];
            C_ADDR_CYCLE:     begin w_old = mcycle_q[31:0];    w_read_only = 1'b1; end
            C_ADDR_CYCLEH:    begin w_old = mcycle_q[63:32];   w_read_only = 1'b1; end
            C_ADDR_INSTRET:   begin w_old = minstret_q[31:0];  w_read_only = 1'b1; end
            C_ADDR_INSTRETH:  begin w_old = minstret_q[63:32]; w_read_only = 1'b1; end
            default:          w_hit = 1'b0;
        endcase

        case (bus.csr_op_i[1:0])
            2'b01:   w_new = w_operand;
            2'b10:   w_new = w_old | w_operand;
            default: w_new = w_old & ~w_operand;
        endcase

        w_illegal = bus.csr_en_i &
                    (~w_hit | w_op_reserved | (w_read_only & ~w_suppress));
        w_we      = bus.csr_en_i & ~bus.stall_i & ~w_illegal & ~w_suppress;
    end

    assign bus.csr_rdata_o = (bus.csr_en_i && !w_illegal) ? w_old : 32'd0;
    assign bus.illegal_o   = w_illegal;

    always_comb begin
        mscratch_d = mscratch_q;
        cy_inh_d   = cy_inh_q;
        ir_inh_d   = ir_inh_q;
        mcycle_d   = mcycle_q;
        minstret_d = minstret_q;

        if (w_we && bus.csr_addr_i == C_ADDR_MSCRATCH)
            mscratch_d = w_new;
        if (w_we && bus.csr_addr_i == C_ADDR_MCOUNTINH) begin
            cy_inh_d = w_new[0];
            ir_inh_d = w_new[2];
        end

        // A software write to either half replaces that cycle's increment.
        if (w_we && bus.csr_addr_i == C_ADDR_MCYCLE)
            mcycle_d[31:0] = w_new;
        else if (w_we && bus.csr_addr_i == C_ADDR_MCYCLEH)
            mcycle_d[63:32] = w_new;
        else if (!cy_inh_q)
            mcycle_d = mcycle_q + 64'd1;

        if (w_we && bus.csr_addr_i == C_ADDR_MINSTRET)
            minstret_d[31:0] = w_new;
        else if (w_we && bus.csr_addr_i == C_ADDR_MINSTRETH)
            minstret_d[63:32] = w_new;
        else if (!ir_inh_q && bus.retire_i)
            minstret_d = minstret_q + 64'd1;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            mscratch_q <= 32'd0;
            cy_inh_q   <= 1'b0;
            ir_inh_q   <= 1'b0;
            mcycle_q   <= 64'd0;
            minstret_q <= 64'd0;
        end else begin
            mscratch_q <= mscratch_d;
            cy_inh_q   <= cy_inh_d;
            ir_inh_q   <= ir_inh_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_csr_unit.sv
// ============================================================================
// Module      : tb_csr_unit
// Description : Directed self-checking bench for csr_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csr_unit;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    csr_unit_if bus ();

    csr_unit dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    // Entered and left just after a rising edge; one access per cycle.
    task automatic csr_op(input logic [2:0] op, input logic [11:0] addr, input logic [4:0] idx,
                          input logic [31:0] data, input logic [31:0] imm,
                          output logic [31:0] rdata, output logic ill);
        bus.csr_en_i   = 1'b1;
        bus.csr_op_i   = op;
        bus.csr_addr_i = addr;
        bus.rs1_idx_i  = idx;
        bus.rs1_data_i = data;
        bus.imm_ext_i  = imm;
        @(negedge clk);
        rdata = bus.csr_rdata_o;
        ill   = bus.illegal_o;
        @(posedge clk);
        #1;
        bus.csr_en_i = 1'b0;
    endtask

    task automatic rd(input logic [11:0] addr, output logic [31:0] val);
        logic ill;
        csr_op(3'b010, addr, 5'd0, 32'hFFFF_FFFF, 32'd0, val, ill);
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        logic [31:0] r;
        logic        ill;
        csr_op(3'b001, addr, 5'd1, data, 32'd0, r, ill);
    endtask

    initial begin
        logic [31:0] r, a, w;
        logic        ill;

        rst            = 1'b1;
        bus.csr_en_i   = 1'b0;
        bus.csr_op_i   = 3'b001;
        bus.csr_addr_i = 12'hC00;
        bus.rs1_idx_i  = 5'd3;
        bus.rs1_data_i = 32'd0;
        bus.imm_ext_i  = 32'd0;
        bus.stall_i    = 1'b0;
        bus.retire_i   = 1'b0;
        #12;
        check("reset_rdata",   bus.csr_rdata_o, 32'd0);
        check("reset_illegal", 32'(bus.illegal_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        rd(12'hB00, r); check("mcycle_after_reset", r, 32'd0);
        rd(12'h340, r); check("mscratch_after_reset", r, 32'd0);

        // RW returns the old value, new value visible next cycle
        csr_op(3'b001, 12'h340, 5'd5, 32'hDEADBEEF, 32'd0, r, ill);
        check("rw_old", r, 32'd0);
        check("rw_legal", 32'(ill), 32'd0);
        rd(12'h340, r); check("rw_new", r, 32'hDEADBEEF);

        // Immediate set/clear and write suppression
        wr(12'h340, 32'h0000_000F);
        csr_op(3'b110, 12'h340, 5'd0, 32'd0, 32'h1A, r, ill);
        check("rsi_old", r, 32'h0F);
        rd(12'h340, r); check("rsi_new", r, 32'h1F);
        csr_op(3'b111, 12'h340, 5'd7, 32'hFFFF_FFFF, 32'd0, r, ill);
        check("rci0_old", r, 32'h1F);
        rd(12'h340, r); check("rci0_nowrite", r, 32'h1F);
        csr_op(3'b111, 12'h340, 5'd0, 32'd0, 32'h3, r, ill);
        rd(12'h340, r); check("rci_clear", r, 32'h1C);
        csr_op(3'b011, 12'h340, 5'd0, 32'hFFFF_FFFF, 32'd0, r, ill);
        rd(12'h340, r); check("rc_x0_nowrite", r, 32'h1C);

        // mcycle carry into the high word
        wr(12'hB00, 32'hFFFF_FFFE);
        wr(12'hB80, 32'd0);
        rd(12'hB00, r); check("mcycle_written", r, 32'hFFFF_FFFE);
        rd(12'hB00, r); check("mcycle_inc", r, 32'hFFFF_FFFF);
        rd(12'hB00, r); check("mcycle_carry_lo", r, 32'd0);
        rd(12'hB80, r); check("mcycle_carry_hi", r, 32'd1);

        // full 64-bit wrap
        wr(12'hB80, 32'hFFFF_FFFF);
        wr(12'hB00, 32'hFFFF_FFFF);
        rd(12'hB80, r); check("mcycleh_max", r, 32'hFFFF_FFFF);
        rd(12'hC80, r); check("cycleh_wrap", r, 32'd0);

        // read-only aliases and illegal accesses
        rd(12'hB00, a);
        csr_op(3'b001, 12'hC00, 5'd3, 32'h1234_5678, 32'd0, r, ill);
        check("ro_write_illegal", 32'(ill), 32'd1);
        check("ro_write_rdata", r, 32'd0);
        rd(12'hB00, r); check("ro_write_nochange", r, a + 32'd2);
        csr_op(3'b010, 12'hC00, 5'd0, 32'hFFFF_FFFF, 32'd0, r, ill);
        check("ro_rs_x0_legal", 32'(ill), 32'd0);
        check("ro_rs_x0_rdata", r, a + 32'd3);
        csr_op(3'b001, 12'h341, 5'd1, 32'd1, 32'd0, r, ill);
        check("unimpl_illegal", 32'(ill), 32'd1);
        csr_op(3'b000, 12'h340, 5'd1, 32'd1, 32'd0, r, ill);
        check("op000_illegal", 32'(ill), 32'd1);
        csr_op(3'b100, 12'h340, 5'd1, 32'd1, 32'd1, r, ill);
        check("op100_illegal", 32'(ill), 32'd1);
        csr_op(3'b110, 12'hC02, 5'd0, 32'd0, 32'd0, r, ill);
        check("ro_rsi0_legal", 32'(ill), 32'd0);
        csr_op(3'b110, 12'hC02, 5'd0, 32'd0, 32'd4, r, ill);
        check("ro_rsi_illegal", 32'(ill), 32'd1);
        rd(12'h340, r); check("mscratch_untouched", r, 32'h1C);

        // mcountinhibit freezes both counters; writing cycle still counts
        bus.retire_i = 1'b1;
        rd(12'hB00, a);
        wr(12'h320, 32'hFFFF_FFFF);
        rd(12'hB00, r); check("inh_write_cycle_counts", r, a + 32'd2);
        rd(12'h320, r); check("mcountinhibit_mask", r, 32'h5);
        rd(12'hB02, w);
        repeat (10) begin @(posedge clk); #1; end
        rd(12'hB00, r); check("mcycle_frozen", r, a + 32'd2);
        rd(12'hB02, r); check("minstret_frozen", r, w);
        wr(12'h320, 32'd0);
        rd(12'hB00, r); check("unfreeze_delay", r, a + 32'd2);
        rd(12'hB00, r); check("mcycle_resumed", r, a + 32'd3);
        rd(12'hB02, w);
        rd(12'hB02, r); check("minstret_resumed", r, w + 32'd1);

        // minstret write-wins and high-half write keeps low half
        wr(12'hB02, 32'd100);
        rd(12'hB02, r); check("minstret_written", r, 32'd100);
        rd(12'hB02, r); check("minstret_retire", r, 32'd101);
        wr(12'hB82, 32'd7);
        rd(12'hC02, r); check("instret_lo_kept", r, 32'd102);
        rd(12'hC82, r); check("instreth_written", r, 32'd7);
        bus.retire_i = 1'b0;
        rd(12'hB02, w);
        rd(12'hB02, r); check("minstret_no_retire", r, w);

        // stall blocks the write but not the cycle counter
        wr(12'h340, 32'h0000_1234);
        bus.stall_i = 1'b1;
        rd(12'hB00, a);
        csr_op(3'b001, 12'h340, 5'd1, 32'h0000_AAAA, 32'd0, r, ill);
        check("stall_rdata", r, 32'h1234);
        rd(12'hB00, r); check("stall_mcycle_inc", r, a + 32'd2);
        bus.stall_i = 1'b0;
        rd(12'h340, r); check("stall_nowrite", r, 32'h1234);

        // asynchronous reset in the middle of a write
        wr(12'h320, 32'h4);
        bus.csr_en_i   = 1'b1;
        bus.csr_op_i   = 3'b001;
        bus.csr_addr_i = 12'h340;
        bus.rs1_idx_i  = 5'd1;
        bus.rs1_data_i = 32'h55;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_rdata", bus.csr_rdata_o, 32'd0);
        @(posedge clk);
        #1;
        bus.csr_en_i = 1'b0;
        rst          = 1'b0;
        rd(12'hB00, r); check("post_reset_mcycle", r, 32'd0);
        rd(12'h340, r); check("post_reset_mscratch", r, 32'd0);
        rd(12'h320, r); check("post_reset_inhibit", r, 32'd0);
        rd(12'hB80, r); check("post_reset_mcycleh", r, 32'd0);
        bus.retire_i = 1'b1;
        rd(12'hB02, r); check("post_reset_minstret", r, 32'd0);
        rd(12'hB02, r); check("post_reset_minstret_inc", r, 32'd1);
        bus.retire_i = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
